// File: rtl/gf_symbol_engine.sv
// gf_symbol_engine
//   GF(2^m) symbol/index engine. After reset it generates its own antilog and
//   log tables by stepping an LFSR built from PRIM_POLY (one entry per cycle),
//   then serves pipelined field operations with valid/ready handshakes.
//
//   Encoding: index 0 is the zero element, index i (1..Q) is alpha^(i-1),
//   Q = 2^m-1. Symbols are MSB-first: bit[m-1] is the alpha^0 coefficient.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   init_done  tables valid, engine accepting requests
//   req_valid  request present
//   req_ready  request accepted when req_valid && req_ready
//   req_op     0 IDX2SYM, 1 SYM2IDX, 2 MUL, 3 INV
//   req_a      operand A (index for IDX2SYM, symbol otherwise)
//   req_b      operand B (symbol, MUL only)
//   rsp_valid  response present
//   rsp_ready  response consumed when rsp_valid && rsp_ready
//   rsp_data   result
//   rsp_err    set only for INV of zero
module gf_symbol_engine #(
    parameter int unsigned               SYMBOL_WIDTH = 4,
    parameter logic [SYMBOL_WIDTH:0]     PRIM_POLY    = 5'b10011
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [SYMBOL_WIDTH-1:0] req_a,
    input  logic [SYMBOL_WIDTH-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SYMBOL_WIDTH-1:0] rsp_data,
    output logic                    rsp_err
);

    localparam int unsigned M     = SYMBOL_WIDTH;
    localparam int unsigned DEPTH = 1 << M;
    localparam logic [M-1:0] QM     = '1;
    localparam logic [M:0]   QX     = {1'b0, QM};
    localparam logic [M-1:0] ALPHA0 = {1'b1, {(M-1){1'b0}}};

    // Feedback taps in MSB-first order: coefficient of x^k lands on bit m-1-k.
    function automatic logic [M-1:0] reduce_mask();
        logic [M-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < M; k++) begin
            r[M-1-k] = PRIM_POLY[k];
        end
        return r;
    endfunction

    localparam logic [M-1:0] RMASK = reduce_mask();

    typedef enum logic { ST_INIT, ST_READY } state_t;
    typedef enum logic [1:0] { OP_IDX2SYM, OP_SYM2IDX, OP_MUL, OP_INV } op_t;

    state_t       state;
    logic [M-1:0] lfsr;
    logic [M-1:0] ecnt;
    logic         wr_en;

    logic [M-1:0] antilog_mem [DEPTH];
    logic [M-1:0] log_mem     [DEPTH];

    // ---------------- table generation ----------------
    // ecnt runs 0..Q: entries are written for 0..Q-1, the ecnt==Q cycle
    // is the handover to READY so init_done rises on edge Q+1.
    assign wr_en = (state == ST_INIT) && (ecnt != QM);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            antilog_mem[ecnt] <= lfsr;
            log_mem[lfsr]     <= ecnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            lfsr      <= ALPHA0;
            ecnt      <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (ecnt == QM) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        // multiply by alpha: shift toward higher powers, fold alpha^m back
                        lfsr <= {1'b0, lfsr[M-1:1]} ^ (lfsr[0] ? RMASK : '0);
                        ecnt <= ecnt + 1'b1;
                    end
                end
                ST_READY: ;
                default: state <= ST_INIT;
            endcase
        end
    end

    // ---------------- request pipeline ----------------
    logic stall, accept;
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = init_done && !stall;
    assign accept    = req_valid && req_ready;

    logic         s1_valid;
    op_t          s1_op;
    logic [M-1:0] s1_a, s1_b;

    logic [M-1:0] la, lb, ea, eb;
    logic [M:0]   sum;
    logic         c1_zero, c1_err, c1_direct;
    logic [M-1:0] c1_val, c1_exp;

    // Stage 1: log lookups and exponent arithmetic
    always_comb begin
        la        = log_mem[s1_a];
        lb        = log_mem[s1_b];
        ea        = la - 1'b1;
        eb        = lb - 1'b1;
        sum       = {1'b0, ea} + {1'b0, eb};
        c1_zero   = 1'b0;
        c1_err    = 1'b0;
        c1_direct = 1'b0;
        c1_val    = '0;
        c1_exp    = '0;
        case (s1_op)
            OP_IDX2SYM: begin
                if (s1_a == '0) c1_zero = 1'b1;
                else            c1_exp  = s1_a - 1'b1;
            end
            OP_SYM2IDX: begin
                c1_direct = 1'b1;
                c1_val    = (s1_a == '0) ? '0 : la;
            end
            OP_MUL: begin
                // modular reduction done in m bits: (s - Q) mod 2^m is exact for s in [Q, 2Q-2]
                if (s1_a == '0 || s1_b == '0) c1_zero = 1'b1;
                else c1_exp = sum[M-1:0] - ((sum >= QX) ? QM : '0);
            end
            OP_INV: begin
                if (s1_a == '0) begin
                    c1_zero = 1'b1;
                    c1_err  = 1'b1;
                end else begin
                    c1_exp = (ea == '0) ? '0 : (QM - ea);
                end
            end
            default: ;
        endcase
    end

    logic         s2_valid, s2_zero, s2_err, s2_direct;
    logic [M-1:0] s2_val, s2_exp;
    logic [M-1:0] c2_data;

    // Stage 2: antilog lookup and zero fix-up
    always_comb begin
        c2_data = '0;
        if (!s2_zero) c2_data = s2_direct ? s2_val : antilog_mem[s2_exp];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_IDX2SYM;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_valid  <= 1'b0;
            s2_zero   <= 1'b0;
            s2_err    <= 1'b0;
            s2_direct <= 1'b0;
            s2_val    <= '0;
            s2_exp    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_op <= op_t'(req_op);
                s1_a  <= req_a;
                s1_b  <= req_b;
            end
            s2_valid  <= s1_valid;
            s2_zero   <= c1_zero;
            s2_err    <= c1_err;
            s2_direct <= c1_direct;
            s2_val    <= c1_val;
            s2_exp    <= c1_exp;
            rsp_valid <= s2_valid;
            if (s2_valid) begin
                rsp_data <= c2_data;
                rsp_err  <= s2_err;
            end
        end
    end

endmodule

// File: tb/tb_gf_symbol_engine.sv
// tb_gf_symbol_engine
//   Scoreboard bench: drivers push expected responses at request accept,
//   negedge monitors compare every presented response against the queue head.
//   Two instances: m=4 (default polynomial) and m=3 (x^3+x+1).
module tb_gf_symbol_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       init_done, req_ready, rsp_valid, rsp_err;
    logic       req_valid, rsp_ready;
    logic [1:0] req_op;
    logic [3:0] req_a, req_b, rsp_data;

    logic       init_done3, req_ready3, rsp_valid3, rsp_err3;
    logic       req_valid3, rsp_ready3;
    logic [1:0] req_op3;
    logic [2:0] req_a3, req_b3, rsp_data3;

    gf_symbol_engine #(.SYMBOL_WIDTH(4), .PRIM_POLY(5'b10011)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    gf_symbol_engine #(.SYMBOL_WIDTH(3), .PRIM_POLY(4'b1011)) dut3 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Ordinary polynomial arithmetic (bit k = x^k), converted to the
    // MSB-first symbol layout only at the end.
    function automatic int alog_sym(input int m, input int poly, input int e);
        int v;
        int r;
        v = 1;
        r = 0;
        for (int i = 0; i < e; i++) begin
            v = v << 1;
            if ((v & (1 << m)) != 0) v = v ^ poly;
        end
        for (int k = 0; k < m; k++)
            if ((v & (1 << k)) != 0) r = r | (1 << (m - 1 - k));
        return r;
    endfunction

    function automatic int log_idx(input int m, input int poly, input int s);
        if (s == 0) return 0;
        for (int e = 0; e < (1 << m) - 1; e++)
            if (alog_sym(m, poly, e) == s) return e + 1;
        return -1;
    endfunction

    function automatic exp_t mk(input int d, input int er);
        exp_t r;
        r.data = 8'(d);
        r.err  = 1'(er);
        return r;
    endfunction

    function automatic exp_t model(input int m, input int poly, input int op, input int a, input int b);
        int q;
        q = (1 << m) - 1;
        case (op)
            0: return mk((a == 0) ? 0 : alog_sym(m, poly, a - 1), 0);
            1: return mk(log_idx(m, poly, a), 0);
            2: begin
                if (a == 0 || b == 0) return mk(0, 0);
                return mk(alog_sym(m, poly, ((log_idx(m, poly, a) - 1) + (log_idx(m, poly, b) - 1)) % q), 0);
            end
            default: begin
                if (a == 0) return mk(0, 1);
                return mk(alog_sym(m, poly, (q - (log_idx(m, poly, a) - 1)) % q), 0);
            end
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic send(input bit wide, input int op, input int a, input int b, input exp_t e);
        int w;
        bit ok;
        w  = 0;
        ok = 1'b0;
        if (wide) begin
            req_valid = 1'b1; req_op = op[1:0]; req_a = a[3:0]; req_b = b[3:0];
        end else begin
            req_valid3 = 1'b1; req_op3 = op[1:0]; req_a3 = a[2:0]; req_b3 = b[2:0];
        end
        while (w < 200) begin
            @(negedge clk);
            if (wide ? req_ready : req_ready3) begin
                ok = 1'b1;
                break;
            end
            w++;
        end
        if (ok) begin
            if (wide) q4.push_back(e);
            else      q3.push_back(e);
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL req_accept_timeout: got no req_ready in 200 cycles, required acceptance");
        end
        @(posedge clk);
        #1;
        if (wide) req_valid = 1'b0;
        else      req_valid3 = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q4.size() != 0 || q3.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_q4", 32'(q4.size()), 0);
        check("drain_q3", 32'(q3.size()), 0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q4.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp4_unexpected: got data 0x%0h, required no response", rsp_data);
            end else begin
                check("rsp4_data", 32'(rsp_data), 32'(q4[0].data));
                check("rsp4_err", 32'(rsp_err), 32'(q4[0].err));
                if (rsp_ready) void'(q4.pop_front());
            end
            if (!rsp_ready) check("req_ready_stall", 32'(req_ready), 0);
        end
    end

    always @(negedge clk) begin
        if (rsp_valid3) begin
            if (q3.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp3_unexpected: got data 0x%0h, required no response", rsp_data3);
            end else begin
                check("rsp3_data", 32'(rsp_data3), 32'(q3[0].data));
                check("rsp3_err", 32'(rsp_err3), 32'(q3[0].err));
                if (rsp_ready3) void'(q3.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int idx_tbl[16] = '{0, 8, 4, 2, 1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9};
    int tbl3[7]     = '{4, 2, 1, 6, 3, 7, 5};
    bit rnd_done;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;  req_op = '0;  req_a = '0;  req_b = '0;  rsp_ready = 1'b1;
        req_valid3 = 1'b0; req_op3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        rnd_done = 1'b0;

        #2;
        check("rst_init_done", 32'(init_done), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        #10 rst_n = 1'b1;

        // first partial run, then a reset pulse after edge 8
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("init4_pre", 32'(init_done), 0);
            check("init3_pre", 32'(init_done3), 32'(k >= 8));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("pulse_init3", 32'(init_done3), 0);
        #1 rst_n = 1'b1;

        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            check("init4_done", 32'(init_done), 32'(k >= 16));
            check("init4_ready", 32'(req_ready), 32'(k >= 16));
            check("init3_done", 32'(init_done3), 32'(k >= 8));
        end

        // MUL latency from an empty pipeline
        req_valid = 1'b1; req_op = 2'd2; req_a = 4'b1100; req_b = 4'b1011;
        @(negedge clk);
        check("lat_req_ready", 32'(req_ready), 1);
        q4.push_back(mk(4'b0010, 0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("lat_edge_n", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("lat_edge_n1", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("lat_edge_n2", 32'(rsp_valid), 1);
        drain();

        // known-answer vectors
        for (int a = 0; a < 16; a++) send(1'b1, 0, a, 0, mk(idx_tbl[a], 0));
        for (int a = 0; a < 16; a++) send(1'b1, 1, idx_tbl[a], 0, mk(a, 0));
        send(1'b1, 2, 4'b0000, 4'b0111, mk(0, 0));
        send(1'b1, 2, 4'b1001, 4'b1000, mk(4'b1001, 0));
        send(1'b1, 3, 4'b0110, 0, mk(4'b1110, 0));
        send(1'b1, 3, 4'b1000, 0, mk(4'b1000, 0));
        send(1'b1, 3, 4'b0000, 0, mk(0, 1));
        drain();

        // 8-request stream with a 3-cycle response stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int op, a, b;
                    op = int'($urandom_range(0, 3));
                    a  = int'($urandom_range(0, 15));
                    b  = int'($urandom_range(0, 15));
                    send(1'b1, op, a, b, model(4, 5'b10011, op, a, b));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 rsp_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();

        // m=3 instance
        for (int a = 1; a <= 7; a++) send(1'b0, 0, a, 0, mk(tbl3[a-1], 0));
        for (int i = 0; i < 12; i++) begin
            int op, a, b;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 7));
            b  = int'($urandom_range(0, 7));
            send(1'b0, op, a, b, model(3, 4'b1011, op, a, b));
        end
        drain();

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    int op, a, b;
                    op = int'($urandom_range(0, 3));
                    a  = int'($urandom_range(0, 15));
                    b  = int'($urandom_range(0, 15));
                    send(1'b1, op, a, b, model(4, 5'b10011, op, a, b));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gf_symbol_engine.md
Name: gf_symbol_engine

Overview:
- Parametrised GF(2^m) symbol/index engine; successor to the fixed 4-bit Symbol_Lookup/Index_Lookup pair.
- After reset it builds its own antilog and log tables by stepping an LFSR defined by PRIM_POLY.
- It then serves pipelined requests: index->symbol, symbol->index, multiply and inverse, with valid/ready handshakes on both request and response.
- Sits between RS encoder/decoder datapaths and any stage needing field arithmetic.

Parameters:
- SYMBOL_WIDTH, 4, m = bits per symbol/index; legal 3..8.
- PRIM_POLY, 5'b10011, primitive polynomial, width SYMBOL_WIDTH+1; bit k = coefficient of x^k; default is x^4+x+1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- init_done, output, 1, tables valid and engine accepting requests.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted when req_valid && req_ready.
- req_op, input, 2, operation: 0 IDX2SYM, 1 SYM2IDX, 2 MUL, 3 INV.
- req_a, input, SYMBOL_WIDTH, operand A (index for IDX2SYM, symbol for the other ops).
- req_b, input, SYMBOL_WIDTH, operand B; symbol; used by MUL only.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
- rsp_data, output, SYMBOL_WIDTH, result.
- rsp_err, output, 1, set only for INV of zero.

Behaviour:
- Encoding, fixed:
  - Q = 2^m-1.
  - Index 0 = zero element; index i (1..Q) = alpha^(i-1).
  - Symbols are MSB-first polynomials: bit[m-1] = coefficient of alpha^0, bit[0] = coefficient of alpha^(m-1).
  - With default parameters, results equal the existing 4-bit tables exactly.
- Reset (rst_n low, async):
  - init_done=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Pipeline valids cleared; FSM to INIT; LFSR state = alpha^0; exponent counter = 0.
  - Table storage is not reset.
- FSM:
  - INIT: one table entry per cycle for e = 0..Q-1. Write antilog[e] = lfsr and log[lfsr] = e+1, then advance lfsr = lfsr*alpha reduced by PRIM_POLY.
  - INIT -> READY on the edge after e = Q-1 is written. init_done rises on the (Q+1)th rising edge after rst_n deasserts (edge 16 for m=4).
  - READY is terminal until reset. Reset in INIT restarts generation from e=0.
- Handshake:
  - req_ready = init_done && !(rsp_valid && !rsp_ready).
  - Requests offered while init_done=0 are ignored, not queued.
  - The response holds rsp_data/rsp_err stable while rsp_valid && !rsp_ready.
- Pipeline: two stages, stall-all.
  - A request accepted at edge N gives rsp_valid at edge N+2 when no stall occurs.
  - Throughput is 1 request per cycle.
  - Stage 1 does the log reads and the exponent arithmetic.
  - Stage 2 does the antilog read and the zero/err fix-up.
  - A stall (rsp_valid && !rsp_ready) freezes both stages.
- Ops:
  - IDX2SYM: a=0 -> 0; else antilog[a-1].
  - SYM2IDX: a=0 -> 0; else log[a].
  - MUL: a=0 or b=0 -> 0. Otherwise form ea=log[a]-1 and eb=log[b]-1, compute s=ea+eb in m+1 bits, subtract Q if s>=Q, result antilog[s].
  - INV: a=0 -> rsp_data=0, rsp_err=1. Otherwise e=log[a]-1; result antilog[(Q-e) mod Q], so e=0 maps to 1.
- rsp_err is 0 for every op other than INV(0).
- Simultaneous accept of a new request and consume of the response is allowed in the same cycle with no bubble.
- Reset mid-operation drops all in-flight requests. No response is emitted for them.

Test Plan:
- Reset release, m=4 -> init_done=0 and req_ready=0 through edge 15, both 1 from edge 16; rst_n pulse at edge 8 restarts the count.
- IDX2SYM sweep of a = 0..15 -> 0000,1000,0100,0010,0001,1100,0110,0011,1101,1010,0101,1110,0111,1111,1011,1001; SYM2IDX of each output returns the original index.
- MUL a=1100, b=1011 -> 0010 at latency 2. MUL a=0000, b=0111 -> 0000. MUL a=1001, b=1000 -> 1001.
- INV a=0110 -> 1110, rsp_err=0. INV a=1000 -> 1000. INV a=0000 -> 0000, rsp_err=1.
- Back-to-back stream of 8 requests with rsp_ready low for 3 cycles mid-stream -> req_ready drops during the stall, no response is lost or duplicated, order is preserved, and rsp_data stays stable while stalled.
- SYMBOL_WIDTH=3, PRIM_POLY=4'b1011 -> init_done on edge 8; IDX2SYM a=1..7 -> 100,010,001,110,011,111,101.
